// File: rtl/div_unit.sv
// Sequential 32-bit restoring divider for RV32M DIV/DIVU/REM/REMU.
// One 33-bit trial subtraction per cycle; divide-by-zero and signed overflow resolve in one cycle.
module div_unit (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_A,
  input  logic [31:0] i_B,
  output logic [31:0] result,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [4:0]  cnt_reg, cnt_next;
  // Partial remainder; its 33rd bit is always zero between iterations, so only 32 bits are stored.
  logic [31:0] rem_reg, rem_next;
  // Dividend bits shift out of the top while quotient bits shift in at the bottom.
  logic [31:0] quo_reg, quo_next;
  logic [31:0] dvs_reg, dvs_next;
  logic        op_rem_reg, op_rem_next;
  logic        q_neg_reg, q_neg_next;
  logic        r_neg_reg, r_neg_next;
  logic [31:0] result_reg, result_next;

  // Operand preparation at accept time
  logic        is_signed;
  logic        a_neg, b_neg;
  logic [31:0] abs_a, abs_b;
  logic        div_zero, sgn_ovf;

  assign is_signed = ~i_op[0];
  assign a_neg     = is_signed & i_A[31];
  assign b_neg     = is_signed & i_B[31];
  assign abs_a     = a_neg ? (~i_A + 32'd1) : i_A;
  assign abs_b     = b_neg ? (~i_B + 32'd1) : i_B;
  assign div_zero  = (i_B == 32'd0);
  assign sgn_ovf   = is_signed && (i_A == 32'h8000_0000) && (i_B == 32'hFFFF_FFFF);

  // One restoring iteration
  logic [32:0] shifted;
  logic [32:0] trial;
  logic        q_bit;
  logic [31:0] iter_rem;
  logic [31:0] iter_quo;
  logic [31:0] fix_quo;
  logic [31:0] fix_rem;

  assign shifted  = {rem_reg, quo_reg[31]};
  assign trial    = shifted - {1'b0, dvs_reg};
  assign q_bit    = ~trial[32];
  assign iter_rem = q_bit ? trial[31:0] : shifted[31:0];
  assign iter_quo = {quo_reg[30:0], q_bit};
  assign fix_quo  = q_neg_reg ? (~iter_quo + 32'd1) : iter_quo;
  assign fix_rem  = r_neg_reg ? (~iter_rem + 32'd1) : iter_rem;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= 5'd0;
      rem_reg    <= 32'd0;
      quo_reg    <= 32'd0;
      dvs_reg    <= 32'd0;
      op_rem_reg <= 1'b0;
      q_neg_reg  <= 1'b0;
      r_neg_reg  <= 1'b0;
      result_reg <= 32'd0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      rem_reg    <= rem_next;
      quo_reg    <= quo_next;
      dvs_reg    <= dvs_next;
      op_rem_reg <= op_rem_next;
      q_neg_reg  <= q_neg_next;
      r_neg_reg  <= r_neg_next;
      result_reg <= result_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    rem_next    = rem_reg;
    quo_next    = quo_reg;
    dvs_next    = dvs_reg;
    op_rem_next = op_rem_reg;
    q_neg_next  = q_neg_reg;
    r_neg_next  = r_neg_reg;
    result_next = result_reg;

    case (state_reg)
      S_IDLE, S_DONE: begin
        state_next = S_IDLE;
        if (i_start) begin
          op_rem_next = i_op[1];
          q_neg_next  = a_neg ^ b_neg;
          r_neg_next  = a_neg;
          quo_next    = abs_a;
          dvs_next    = abs_b;
          rem_next    = 32'd0;
          cnt_next    = 5'd0;
          if (div_zero) begin
            result_next = i_op[1] ? i_A : 32'hFFFF_FFFF;
            state_next  = S_DONE;
          end else if (sgn_ovf) begin
            result_next = i_op[1] ? 32'd0 : 32'h8000_0000;
            state_next  = S_DONE;
          end else begin
            state_next  = S_CALC;
          end
        end
      end
      S_CALC: begin
        rem_next = iter_rem;
        quo_next = iter_quo;
        cnt_next = cnt_reg + 5'd1;
        if (cnt_reg == 5'd31) begin
          result_next = op_rem_reg ? fix_rem : fix_quo;
          state_next  = S_DONE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign result = result_reg;
  assign busy   = (state_reg == S_CALC);
  assign done   = (state_reg == S_DONE);

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RV32M corner cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_div_unit;

  logic        i_clk;
  logic        i_rst;
  logic        i_start;
  logic [1:0]  i_op;
  logic [31:0] i_A;
  logic [31:0] i_B;
  logic [31:0] result;
  logic        busy;
  logic        done;

  int n_checks;
  int n_errors;

  div_unit dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_op    (i_op),
    .i_A     (i_A),
    .i_B     (i_B),
    .result  (result),
    .busy    (busy),
    .done    (done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V division semantics from integer arithmetic on 64-bit values
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (op[0]) begin
      sa = longint'(a);
      sb = longint'(b);
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end
    q = sa / sb;
    r = sa % sb;
    return op[1] ? r[31:0] : q[31:0];
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Drive a start for one clock; called at posedge+1 so the start is sampled at the next edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    i_start = 1'b1;
    i_op    = op;
    i_A     = a;
    i_B     = b;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
  endtask

  // Returns with done visible (inside the DONE cycle). lat counts edges from start sample to done sample.
  task automatic wait_done(output int lat, output int busy_n, output bit got);
    int k;
    k = 0;
    busy_n = 0;
    got = 1'b0;
    while (k < 40) begin
      if (busy && done) check("busy_done_excl", 32'(busy & done), 32'd0);
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) busy_n++;
      @(posedge i_clk);
      #1;
      k++;
    end
    lat = k + 1;
  endtask

  task automatic run_check(input string tag, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
    int lat, busy_n;
    bit got;
    bit sp;
    sp = is_special(op, a, b);
    issue(op, a, b);
    wait_done(lat, busy_n, got);
    check({tag, "_timeout"}, 32'(got), 32'd1);
    check({tag, "_result"}, result, exp);
    check({tag, "_latency"}, 32'(lat), sp ? 32'd1 : 32'd33);
    check({tag, "_busy_cycles"}, 32'(busy_n), sp ? 32'd0 : 32'd32);
    $display("op=%0d A=%h B=%h result=%h latency=%0d busy=%0d", op, a, b, result, lat, busy_n);
  endtask

  // One idle cycle after DONE: done must have dropped and result must hold.
  task automatic idle_check(input string tag, input logic [31:0] exp);
    @(posedge i_clk);
    #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    check({tag, "_hold"}, result, exp);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat, busy_n;
    bit got;
    bit saw_done;
    logic [1:0]  op;
    logic [31:0] a, b, exp;

    n_checks = 0;
    n_errors = 0;
    i_rst   = 1'b1;
    i_start = 1'b0;
    i_op    = 2'b00;
    i_A     = 32'd0;
    i_B     = 32'd0;
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_result", result, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;

    // Basic unsigned
    run_check("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14);
    idle_check("divu_100_7", 32'd14);
    run_check("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2);
    idle_check("remu_100_7", 32'd2);

    // Signed
    run_check("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    idle_check("div_m7_2", 32'hFFFF_FFFD);
    run_check("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    idle_check("rem_m7_2", 32'hFFFF_FFFF);
    run_check("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1);
    idle_check("rem_7_m2", 32'd1);

    // Divide by zero and signed overflow
    run_check("divu_5_0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF);
    idle_check("divu_5_0", 32'hFFFF_FFFF);
    run_check("rem_min_0", 2'b10, 32'h8000_0000, 32'd0, 32'h8000_0000);
    idle_check("rem_min_0", 32'h8000_0000);
    run_check("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    idle_check("div_ovf", 32'h8000_0000);
    run_check("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    idle_check("rem_ovf", 32'd0);

    // Back-to-back: second start issued during DONE of the first
    run_check("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
    run_check("b2b_divu_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'd1);
    run_check("b2b_special", 2'b01, 32'd9, 32'd0, 32'hFFFF_FFFF);
    run_check("b2b_after_special", 2'b00, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);
    idle_check("b2b", 32'hFFFF_FFF2);

    // Reset mid-CALC: abort after 10 iterations, no done pulse afterwards
    issue(2'b01, 32'd1000, 32'd3);
    repeat (9) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", result, 32'd0);
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge i_clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);
    $display("abort: busy=%0d done=%0d result=%h", busy, done, result);

    // start toggled mid-CALC must not disturb the operation in flight
    issue(2'b01, 32'd9, 32'd3);
    repeat (4) @(posedge i_clk);
    #1;
    i_start = 1'b1;
    i_op    = 2'b11;
    i_A     = 32'd12345;
    i_B     = 32'd0;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    wait_done(lat, busy_n, got);
    check("midcalc_timeout", 32'(got), 32'd1);
    check("midcalc_result", result, 32'd3);
    check("midcalc_latency", 32'(lat + 5), 32'd33);
    $display("midcalc: result=%h latency=%0d", result, lat + 5);
    idle_check("midcalc", 32'd3);

    // Randomized operations against the reference model
    for (int n = 0; n < 40; n++) begin
      op  = 2'($urandom_range(0, 3));
      a   = pick_operand();
      b   = pick_operand();
      exp = model(op, a, b);
      run_check($sformatf("rand%0d", n), op, a, b, exp);
      if ($urandom_range(0, 1) == 0) idle_check($sformatf("rand%0d", n), exp);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
